// File: rtl/mdu_iterative.sv
// mdu_iterative: iterative multiply/divide unit with architectural HI/LO.
//
// Sits beside the combinational ALU in the execute stage. Signed and
// unsigned multiply and divide run one bit per cycle. Each arithmetic
// operation has a constant latency of WIDTH+2 busy cycles, followed by a
// single done cycle. MTHI/MTLO write HI/LO directly without going busy.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous, active-high reset
//   start        request, sampled only while busy=0 (IDLE or DONE)
//   op           000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI,
//                101 MTLO, 11x reserved (ignored)
//   a            multiplicand / dividend / move-to data
//   b            multiplier / divisor
//   busy         high while an arithmetic operation is in progress
//   done         one-cycle pulse once hi/lo hold the new result
//   hi           HI register (high product half / remainder)
//   lo           LO register (low product half / quotient)
//   div_by_zero  registered flag, valid with done
module mdu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Operation context captured at start.
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               dz;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;

  // Magnitude of an operand; MIN maps to 2^(WIDTH-1), which is
  // representable as an unsigned WIDTH-bit value.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic sgn);
    logic [WIDTH-1:0] r;
    r = v;
    if (sgn && v < 0) r = -v;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v,
                                                     input logic neg);
    return neg ? -v : v;
  endfunction

  logic can_accept;
  logic accept_arith;
  logic op_signed;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign can_accept   = (state == S_IDLE) || (state == S_DONE);
  assign accept_arith = can_accept && start && !op[2];
  assign op_signed    = ~op[0];
  assign mag_a        = magnitude($signed(a), op_signed);
  assign mag_b        = magnitude($signed(b), op_signed);

  // Shift-add multiply step: acc = {partial product, remaining multiplier}.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide step: acc = {partial remainder, dividend/quotient bits}.
  // The shifted remainder needs one extra bit before the trial subtract.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_next;
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_ok    = ~div_diff[WIDTH];
  assign div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      acc[WIDTH-2:0], div_ok};

  // Sign correction applied in FIX. DIV MIN/-1 needs no special case: the
  // magnitude quotient 2^(WIDTH-1) with a positive sign already reads as MIN
  // and the remainder is zero.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  assign prod = cond_neg_2w(acc, neg_q);

  always_comb begin
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div) begin
      if (dz) begin
        fix_lo = '1;
        fix_hi = a_raw;
      end else begin
        fix_lo = cond_neg_w(acc[WIDTH-1:0], neg_q);
        fix_hi = cond_neg_w(acc[2*WIDTH-1:WIDTH], neg_r);
      end
    end
  end

  // Control FSM and architectural registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (start) begin
            if (!op[2]) begin
              state <= S_RUN;
              busy  <= 1'b1;
              cnt   <= CNT_W'(WIDTH);
            end else if (!op[1]) begin
              if (op[0]) lo <= a;
              else       hi <= a;
              done        <= 1'b1;
              div_by_zero <= 1'b0;
            end
          end
        end
        // One extra RUN cycle with cnt==0 hands over to FIX, giving
        // WIDTH+2 busy cycles in total.
        S_RUN: begin
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        S_FIX: begin
          hi          <= fix_hi;
          lo          <= fix_lo;
          div_by_zero <= dz;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath: capture on accept, iterate in RUN. A zero divisor freezes the
  // accumulator while RUN still counts down so latency stays constant.
  always_ff @(posedge clk) begin
    if (accept_arith) begin
      is_div <= op[1];
      a_raw  <= a;
      dz     <= op[1] && (b == '0);
      neg_q  <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r  <= op_signed && op[1] && a[WIDTH-1];
      if (op[1]) begin
        acc  <= {{WIDTH{1'b0}}, mag_a};
        opnd <= mag_b;
      end else begin
        acc  <= {{WIDTH{1'b0}}, mag_b};
        opnd <= mag_a;
      end
    end else if (state == S_RUN && cnt != '0 && !dz) begin
      acc <= is_div ? div_next : mul_next;
    end
  end

endmodule
